// File: rtl/grey_pkg.sv
// Shared definitions for the two-digit Grey-style counter decoder:
// code table, digit decode, successor rule and lock state encoding.
package grey_pkg;

  localparam int unsigned CODE_W = 5;
  localparam int unsigned BCD_W  = 4;

  // Code for each digit value 0..9
  localparam logic [CODE_W-1:0] GREY_0 = 5'b00000;
  localparam logic [CODE_W-1:0] GREY_1 = 5'b00001;
  localparam logic [CODE_W-1:0] GREY_2 = 5'b00011;
  localparam logic [CODE_W-1:0] GREY_3 = 5'b00010;
  localparam logic [CODE_W-1:0] GREY_4 = 5'b00110;
  localparam logic [CODE_W-1:0] GREY_5 = 5'b00100;
  localparam logic [CODE_W-1:0] GREY_6 = 5'b01100;
  localparam logic [CODE_W-1:0] GREY_7 = 5'b01000;
  localparam logic [CODE_W-1:0] GREY_8 = 5'b11000;
  localparam logic [CODE_W-1:0] GREY_9 = 5'b10000;

  // Decoded digit; val is 4'hF whenever valid is low
  typedef struct packed {
    logic             valid;
    logic [BCD_W-1:0] val;
  } digit_t;

  typedef enum logic {
    ACQUIRE = 1'b0,
    LOCKED  = 1'b1
  } state_t;

  // Map a 5-bit code to its digit value
  function automatic digit_t grey_to_digit(input logic [CODE_W-1:0] code);
    digit_t d;
    d.valid = 1'b1;
    case (code)
      GREY_0:  d.val = 4'd0;
      GREY_1:  d.val = 4'd1;
      GREY_2:  d.val = 4'd2;
      GREY_3:  d.val = 4'd3;
      GREY_4:  d.val = 4'd4;
      GREY_5:  d.val = 4'd5;
      GREY_6:  d.val = 4'd6;
      GREY_7:  d.val = 4'd7;
      GREY_8:  d.val = 4'd8;
      GREY_9:  d.val = 4'd9;
      default: begin
        d.valid = 1'b0;
        d.val   = 4'hF;
      end
    endcase
    return d;
  endfunction

  // Successor code in the counter sequence, 9 wraps to 0; invalid codes map to themselves
  function automatic logic [CODE_W-1:0] grey_next(input logic [CODE_W-1:0] code);
    logic [CODE_W-1:0] n;
    case (code)
      GREY_0:  n = GREY_1;
      GREY_1:  n = GREY_2;
      GREY_2:  n = GREY_3;
      GREY_3:  n = GREY_4;
      GREY_4:  n = GREY_5;
      GREY_5:  n = GREY_6;
      GREY_6:  n = GREY_7;
      GREY_7:  n = GREY_8;
      GREY_8:  n = GREY_9;
      GREY_9:  n = GREY_0;
      default: n = code;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/grey_digit_decode.sv
// Combinational decode of one 5-bit digit code to BCD plus valid flag.
module grey_digit_decode
  import grey_pkg::*;
(
  input  logic [CODE_W-1:0] i_code,
  output logic [BCD_W-1:0]  o_bcd_c,
  output logic              o_valid_c
);

  digit_t dig;

  // Table lookup through the shared decode function
  always_comb begin
    dig       = grey_to_digit(i_code);
    o_bcd_c   = dig.val;
    o_valid_c = dig.valid;
  end

endmodule

// File: rtl/grey_decode.sv
// Receive-side decoder for the two-digit Grey-style counter code.
// Stage 1 registers the codes, stage 2 classifies the change against the
// previous sample and registers all outputs. Lock FSM and saturating error count.
// Optional: GREY_DECODE_SYNC_EN inserts a 2-flop synchronizer ahead of stage 1.
module grey_decode
  import grey_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned ERR_W    = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [CODE_W-1:0] i_ones,
  input  logic [CODE_W-1:0] i_tens,
  output logic [BCD_W-1:0]  o_ones_bcd,
  output logic [BCD_W-1:0]  o_tens_bcd,
  output logic              o_valid,
  output logic              o_step,
  output logic              o_err,
  output logic              o_locked,
  output logic [ERR_W-1:0]  o_err_count
);

  localparam int unsigned LCNT_W = 4;

  logic [CODE_W-1:0] s_ones, s_tens;

`ifdef GREY_DECODE_SYNC_EN
  localparam int unsigned FILL_W = 3;

  logic [CODE_W-1:0] sync1_ones, sync1_tens, sync2_ones, sync2_tens;

  // Two-flop synchronizer for an asynchronous code source
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_ones <= '0;
      sync1_tens <= '0;
      sync2_ones <= '0;
      sync2_tens <= '0;
    end else begin
      sync1_ones <= i_ones;
      sync1_tens <= i_tens;
      sync2_ones <= sync1_ones;
      sync2_tens <= sync1_tens;
    end
  end

  assign s_ones = sync2_ones;
  assign s_tens = sync2_tens;
`else
  localparam int unsigned FILL_W = 1;

  assign s_ones = i_ones;
  assign s_tens = i_tens;
`endif

  logic [FILL_W-1:0] fill_q;
  logic              cur_full;
  logic [CODE_W-1:0] cur_ones, cur_tens;
  logic [CODE_W-1:0] prev_ones, prev_tens;
  logic              prev_full;

  // Stage 1: capture codes; fill_q marks when cur holds a real post-reset sample
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fill_q   <= '0;
      cur_ones <= '0;
      cur_tens <= '0;
    end else begin
      fill_q   <= (fill_q << 1) | FILL_W'(1);
      cur_ones <= s_ones;
      cur_tens <= s_tens;
    end
  end

  assign cur_full = fill_q[FILL_W-1];

  logic [BCD_W-1:0] cur_ones_bcd, cur_tens_bcd;
  logic             cur_ones_vld, cur_tens_vld;

  grey_digit_decode u_ones_dec (
    .i_code    (cur_ones),
    .o_bcd_c   (cur_ones_bcd),
    .o_valid_c (cur_ones_vld)
  );

  grey_digit_decode u_tens_dec (
    .i_code    (cur_tens),
    .o_bcd_c   (cur_tens_bcd),
    .o_valid_c (cur_tens_vld)
  );

  digit_t prev_ones_d, prev_tens_d;
  logic   cur_vld, prev_vld;
  logic   hold, adv, carry;
  logic   step_c, err_c;

  assign prev_ones_d = grey_to_digit(prev_ones);
  assign prev_tens_d = grey_to_digit(prev_tens);
  assign cur_vld     = cur_ones_vld & cur_tens_vld;
  assign prev_vld    = prev_ones_d.valid & prev_tens_d.valid;

  // Transition shapes, meaningful only when both samples are valid
  assign hold  = (cur_ones_bcd == prev_ones_d.val) && (cur_tens_bcd == prev_tens_d.val);
  assign adv   = (cur_tens == prev_tens) && (prev_ones_d.val != 4'd9) &&
                 (cur_ones == grey_next(prev_ones));
  assign carry = (prev_ones_d.val == 4'd9) && (cur_ones == GREY_0) &&
                 (cur_tens == grey_next(prev_tens));

  // Classify the cur-vs-prev change into step / error events
  always_comb begin
    step_c = 1'b0;
    err_c  = 1'b0;
    if (cur_full && prev_full) begin
      if (!cur_vld) begin
        err_c = 1'b1;
      end else if (prev_vld) begin
        if (adv || carry) begin
          step_c = 1'b1;
        end else if (!hold) begin
          err_c = 1'b1;
        end
      end
    end
  end

  state_t            state_q, state_d;
  logic [LCNT_W-1:0] lock_cnt_q, lock_cnt_d, lock_inc;

  // Lock FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ACQUIRE;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Lock FSM next state: count steps in ACQUIRE, any error drops back
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    lock_inc   = lock_cnt_q + LCNT_W'(1);
    case (state_q)
      ACQUIRE: begin
        if (err_c) begin
          lock_cnt_d = '0;
        end else if (step_c) begin
          if (lock_inc == LCNT_W'(LOCK_CNT)) begin
            state_d    = LOCKED;
            lock_cnt_d = '0;
          end else begin
            lock_cnt_d = lock_inc;
          end
        end
      end
      LOCKED: begin
        if (err_c) begin
          state_d    = ACQUIRE;
          lock_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ACQUIRE;
        lock_cnt_d = '0;
      end
    endcase
  end

  // Stage 2: register outputs and roll cur into prev
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_ones_bcd  <= '0;
      o_tens_bcd  <= '0;
      o_valid     <= 1'b0;
      o_step      <= 1'b0;
      o_err       <= 1'b0;
      o_locked    <= 1'b0;
      o_err_count <= '0;
      prev_ones   <= '0;
      prev_tens   <= '0;
      prev_full   <= 1'b0;
    end else begin
      o_step   <= step_c;
      o_err    <= err_c;
      o_locked <= (state_d == LOCKED);
      if (err_c && (o_err_count != {ERR_W{1'b1}})) begin
        o_err_count <= o_err_count + ERR_W'(1);
      end
      if (cur_full) begin
        o_ones_bcd <= cur_ones_bcd;
        o_tens_bcd <= cur_tens_bcd;
        o_valid    <= cur_vld;
        prev_ones  <= cur_ones;
        prev_tens  <= cur_tens;
        prev_full  <= 1'b1;
      end
    end
  end

endmodule
